instr_encoder: RTL and testbench

Immediate-packing instruction encoder. It takes a base instruction word, an immediate value and a RISC-V immediate format, and produces the 32-bit instruction with the immediate scattered into the format's bit fields. It also range- and alignment-checks the immediate. Used by the debug/program-buffer path and the self-test instruction injector, and sits in front of the fetch-side injection mux. It is a 2-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/instr_encoder.sv | 215 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder that scatters an immediate into a RISC-V I/S/B/J/U instruction word.
// Optional statistics counters are built only when INSTR_ENC_STATS_EN is defined.
module instr_encoder #(
   parameter int unsigned STATS_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [2:0]         imm_src_i,
   input  logic [31:0]        imm_i,
   input  logic [31:0]        base_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [31:0]        instr_o,
   output logic               range_err_o,
   output logic               align_err_o,
   output logic               fmt_err_o,
   output logic [STATS_W-1:0] enc_cnt_o,
   output logic [STATS_W-1:0] err_cnt_o
);

   localparam logic [2:0] SrcI = 3'b000;
   localparam logic [2:0] SrcS = 3'b001;
   localparam logic [2:0] SrcB = 3'b010;
   localparam logic [2:0] SrcJ = 3'b011;
   localparam logic [2:0] SrcU = 3'b100;

   localparam logic [31:0] MaskI  = 32'hfff0_0000;
   localparam logic [31:0] MaskSb = 32'hfe00_0f80;
   localparam logic [31:0] MaskJu = 32'hffff_f000;

   // Combinational encode of the incoming request
   logic [31:0] enc_mask;
   logic [31:0] enc_place;
   logic [31:0] enc_instr;
   logic        enc_range;
   logic        enc_align;
   logic        enc_fmt;
   logic        ext11_ok;
   logic        ext12_ok;
   logic        ext20_ok;

   // Pipeline state
   logic        s1_valid_q, s1_valid_d;
   logic [31:0] s1_instr_q, s1_instr_d;
   logic        s1_range_q, s1_range_d;
   logic        s1_align_q, s1_align_d;
   logic        s1_fmt_q, s1_fmt_d;
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] s2_instr_q, s2_instr_d;
   logic        s2_range_q, s2_range_d;
   logic        s2_align_q, s2_align_d;
   logic        s2_fmt_q, s2_fmt_d;

   logic        s1_adv;
   logic        s2_adv;
   logic        req_fire;

   // Sign-extension checks: the upper bits must all match the format's sign bit
   assign ext11_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
   assign ext12_ok = (&imm_i[31:12]) | ~(|imm_i[31:12]);
   assign ext20_ok = (&imm_i[31:20]) | ~(|imm_i[31:20]);

   always_comb begin
      enc_mask  = '0;
      enc_place = '0;
      enc_range = 1'b0;
      enc_align = 1'b0;
      enc_fmt   = 1'b0;
      case (imm_src_i)
         SrcI: begin
            enc_mask  = MaskI;
            enc_place = {imm_i[11:0], 20'h0_0000};
            enc_range = ~ext11_ok;
         end
         SrcS: begin
            enc_mask  = MaskSb;
            enc_place = {imm_i[11:5], 13'h0000, imm_i[4:0], 7'h00};
            enc_range = ~ext11_ok;
         end
         SrcB: begin
            enc_mask  = MaskSb;
            enc_place = {imm_i[12], imm_i[10:5], 13'h0000, imm_i[4:1], imm_i[11], 7'h00};
            enc_range = ~ext12_ok;
            enc_align = imm_i[0];
         end
         SrcJ: begin
            enc_mask  = MaskJu;
            enc_place = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'h000};
            enc_range = ~ext20_ok;
            enc_align = imm_i[0];
         end
         SrcU: begin
            enc_mask  = MaskJu;
            enc_place = {imm_i[31:12], 12'h000};
            enc_range = |imm_i[11:0];
         end
         default: begin
            // Invalid format: pass base through untouched, only fmt_err raised
            enc_fmt = 1'b1;
         end
      endcase
      enc_instr = (base_i & ~enc_mask) | enc_place;
   end

   always_comb begin
      s2_adv      = ~s2_valid_q | rsp_ready_i;
      s1_adv      = ~s1_valid_q | s2_adv;
      req_ready_o = ~rst_i & s1_adv;
      req_fire    = req_valid_i & req_ready_o;

      s1_valid_d = s1_valid_q;
      s1_instr_d = s1_instr_q;
      s1_range_d = s1_range_q;
      s1_align_d = s1_align_q;
      s1_fmt_d   = s1_fmt_q;
      if (s1_adv) begin
         s1_valid_d = req_fire;
         if (req_fire) begin
            s1_instr_d = enc_instr;
            s1_range_d = enc_range;
            s1_align_d = enc_align;
            s1_fmt_d   = enc_fmt;
         end
      end

      s2_valid_d = s2_valid_q;
      s2_instr_d = s2_instr_q;
      s2_range_d = s2_range_q;
      s2_align_d = s2_align_q;
      s2_fmt_d   = s2_fmt_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_instr_d = s1_instr_q;
            s2_range_d = s1_range_q;
            s2_align_d = s1_align_q;
            s2_fmt_d   = s1_fmt_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_instr_q <= '0;
         s1_range_q <= 1'b0;
         s1_align_q <= 1'b0;
         s1_fmt_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_instr_q <= '0;
         s2_range_q <= 1'b0;
         s2_align_q <= 1'b0;
         s2_fmt_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_instr_q <= s1_instr_d;
         s1_range_q <= s1_range_d;
         s1_align_q <= s1_align_d;
         s1_fmt_q   <= s1_fmt_d;
         s2_valid_q <= s2_valid_d;
         s2_instr_q <= s2_instr_d;
         s2_range_q <= s2_range_d;
         s2_align_q <= s2_align_d;
         s2_fmt_q   <= s2_fmt_d;
      end
   end

   assign rsp_valid_o = s2_valid_q;
   assign instr_o     = s2_instr_q;
   assign range_err_o = s2_range_q;
   assign align_err_o = s2_align_q;
   assign fmt_err_o   = s2_fmt_q;

`ifdef INSTR_ENC_STATS_EN
   localparam logic [STATS_W-1:0] CntOne = {{(STATS_W-1){1'b0}}, 1'b1};

   logic               rsp_fire;
   logic               rsp_err;
   logic [STATS_W-1:0] enc_cnt_q, enc_cnt_d;
   logic [STATS_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      rsp_fire  = s2_valid_q & rsp_ready_i;
      rsp_err   = s2_range_q | s2_align_q | s2_fmt_q;
      enc_cnt_d = enc_cnt_q;
      err_cnt_d = err_cnt_q;
      // Both counters stick at all-ones
      if (rsp_fire && !(&enc_cnt_q)) begin
         enc_cnt_d = enc_cnt_q + CntOne;
      end
      if (rsp_fire && rsp_err && !(&err_cnt_q)) begin
         err_cnt_d = err_cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enc_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         enc_cnt_q <= enc_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign enc_cnt_o = enc_cnt_q;
   assign err_cnt_o = err_cnt_q;
`else
   assign enc_cnt_o = '0;
   assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, backpressure, streaming, reset flush,
// and a randomized phase scored against a queue of expectations from an arithmetic reference.
module tb_instr_encoder;

   localparam int unsigned StatsW = 4;
   localparam int          CntMax = (1 << StatsW) - 1;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [2:0]        imm_src_i;
   logic [31:0]       imm_i;
   logic [31:0]       base_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [31:0]       instr_o;
   logic              range_err_o;
   logic              align_err_o;
   logic              fmt_err_o;
   logic [StatsW-1:0] enc_cnt_o;
   logic [StatsW-1:0] err_cnt_o;

   instr_encoder #(.STATS_W(StatsW)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .imm_src_i   (imm_src_i),
      .imm_i       (imm_i),
      .base_i      (base_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .instr_o     (instr_o),
      .range_err_o (range_err_o),
      .align_err_o (align_err_o),
      .fmt_err_o   (fmt_err_o),
      .enc_cnt_o   (enc_cnt_o),
      .err_cnt_o   (err_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic        rng;
      logic        aln;
      logic        fmt;
      logic [31:0] imm;
      logic [2:0]  src;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        nxt;
   int          n_cmp = 0;
   int          n_mis = 0;
   int          n_rsp = 0;
   int          exp_enc = 0;
   int          exp_err = 0;
   logic        hold_v = 1'b0;
   logic [34:0] hold_val;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: ranges as signed intervals, placement straight from the format tables
   function automatic exp_t model(input logic [2:0] src, input logic [31:0] imm,
                                  input logic [31:0] base);
      exp_t        e;
      longint      s;
      logic [31:0] mask;
      logic [31:0] p;
      s     = longint'($signed(imm));
      e.imm = imm;
      e.src = src;
      e.rng = 1'b0;
      e.aln = 1'b0;
      e.fmt = 1'b0;
      mask  = '0;
      p     = '0;
      case (src)
         3'd0: begin
            mask  = 32'hfff0_0000;
            p     = {imm[11:0], 20'h0};
            e.rng = (s < -2048) || (s > 2047);
         end
         3'd1: begin
            mask  = 32'hfe00_0f80;
            p     = {imm[11:5], 13'h0, imm[4:0], 7'h0};
            e.rng = (s < -2048) || (s > 2047);
         end
         3'd2: begin
            mask  = 32'hfe00_0f80;
            p     = {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0};
            e.rng = (s < -4096) || (s > 4095);
            e.aln = (imm % 2) != 0;
         end
         3'd3: begin
            mask  = 32'hffff_f000;
            p     = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0};
            e.rng = (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1);
            e.aln = (imm % 2) != 0;
         end
         3'd4: begin
            mask  = 32'hffff_f000;
            p     = imm - (imm % 4096);
            e.rng = (imm % 4096) != 0;
         end
         default: e.fmt = 1'b1;
      endcase
      e.instr = (base & ~mask) | p;
      return e;
   endfunction

   function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] src);
      case (src)
         3'd0:    return {{20{i[31]}}, i[31:20]};
         3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return {i[31:12], 12'h0};
      endcase
   endfunction

   // One clock: score handshakes at the negedge, then check counters just after the posedge
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (rst_i) begin
         hold_v  = 1'b0;
         exp_enc = 0;
         exp_err = 0;
      end else begin
         if (hold_v) begin
            chk("stable", {29'h0, instr_o[31:29]} ^ 32'(hold_val[34:32]) ^ 32'(hold_val[31:0])
                ^ instr_o, {29'h0, instr_o[31:29]} ^ 32'(hold_val[34:32]));
            chk("stable_flags", {29'h0, range_err_o, align_err_o, fmt_err_o},
                32'(hold_val[34:32]));
         end
         if (req_valid_i && req_ready_o) exp_q.push_back(nxt);
         if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("spurious_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
               e = exp_q.pop_front();
               n_rsp++;
               chk("instr", instr_o, e.instr);
               chk("range_err", 32'(range_err_o), 32'(e.rng));
               chk("align_err", 32'(align_err_o), 32'(e.aln));
               chk("fmt_err", 32'(fmt_err_o), 32'(e.fmt));
               if (!(e.rng || e.aln || e.fmt)) chk("roundtrip", decode(instr_o, e.src), e.imm);
               if (exp_enc < CntMax) exp_enc++;
               if ((e.rng || e.aln || e.fmt) && exp_err < CntMax) exp_err++;
            end
         end
         hold_v   = rsp_valid_o && !rsp_ready_i;
         hold_val = {range_err_o, align_err_o, fmt_err_o, instr_o};
      end
      @(posedge clk);
      #1;
`ifdef INSTR_ENC_STATS_EN
      chk("enc_cnt", 32'(enc_cnt_o), 32'(exp_enc));
      chk("err_cnt", 32'(err_cnt_o), 32'(exp_err));
`else
      chk("enc_cnt", 32'(enc_cnt_o), 32'd0);
      chk("err_cnt", 32'(err_cnt_o), 32'd0);
`endif
   endtask

   task automatic drive_rand();
      logic [2:0]  src;
      logic [31:0] imm;
      logic [31:0] base;
      src  = 3'($urandom_range(0, 7));
      base = $urandom;
      case ($urandom_range(0, 3))
         0:       imm = $urandom;
         1:       imm = 32'(int'($urandom_range(0, 8191)) - 4096);
         2:       imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hffff_fffe;
         default: imm = $urandom & 32'hffff_f000;
      endcase
      imm_src_i = src;
      imm_i     = imm;
      base_i    = base;
      nxt       = model(src, imm, base);
   endtask

   task automatic send_dir(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base,
                           input logic [31:0] ei, input logic er, input logic ea, input logic ef);
      imm_src_i   = src;
      imm_i       = imm;
      base_i      = base;
      nxt.instr   = ei;
      nxt.rng     = er;
      nxt.aln     = ea;
      nxt.fmt     = ef;
      nxt.imm     = imm;
      nxt.src     = src;
      req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      for (int k = 0; k < 6 && exp_q.size() != 0; k++) step();
      chk("dir_drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      imm_src_i   = '0;
      imm_i       = '0;
      base_i      = '0;
      nxt         = model(3'd0, 32'd0, 32'd0);
      step();
      step();
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_flags", {29'h0, range_err_o, align_err_o, fmt_err_o}, 32'd0);

      rst_i       = 1'b0;
      rsp_ready_i = 1'b1;
      send_dir(3'b000, 32'hffff_f800, 32'h0000_0013, 32'h8000_0013, 1'b0, 1'b0, 1'b0);
      send_dir(3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, 1'b0, 1'b0);
      send_dir(3'b001, 32'h0000_07ff, 32'h0000_2023, 32'h7e00_2fa3, 1'b0, 1'b0, 1'b0);
      send_dir(3'b100, 32'h1234_5000, 32'h0000_0537, 32'h1234_5537, 1'b0, 1'b0, 1'b0);
      send_dir(3'b100, 32'h1234_5001, 32'h0000_0537, 32'h1234_5537, 1'b1, 1'b0, 1'b0);
      send_dir(3'b010, 32'hffff_fffc, 32'h0000_0063, 32'hfe00_0ee3, 1'b0, 1'b0, 1'b0);
      send_dir(3'b011, 32'h0010_0000, 32'h0000_006f, 32'h8000_006f, 1'b1, 1'b0, 1'b0);
      send_dir(3'b011, 32'h0000_0003, 32'h0000_006f, 32'h0020_006f, 1'b0, 1'b1, 1'b0);
      send_dir(3'b111, 32'h0000_0123, 32'hdead_beef, 32'hdead_beef, 1'b0, 1'b0, 1'b1);

      // Backpressure: two fit, the third waits until the output drains
      rsp_ready_i = 1'b0;
      n_rsp       = 0;
      for (int i = 0; i < 3; i++) begin
         drive_rand();
         req_valid_i = 1'b1;
         chk("bp_ready", 32'(req_ready_o), (i < 2) ? 32'd1 : 32'd0);
         step();
      end
      chk("bp_held", 32'(exp_q.size()), 32'd2);
      rsp_ready_i = 1'b1;
      step();
      req_valid_i = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
      chk("bp_delivered", 32'(n_rsp), 32'd3);

      // Streaming after a fresh reset: latency 2 edges, then one response per cycle
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         if (i < 8) drive_rand();
         req_valid_i = (i < 8);
         step();
         chk("stream_valid", 32'(rsp_valid_o), (i >= 1 && i <= 8) ? 32'd1 : 32'd0);
      end
`ifdef INSTR_ENC_STATS_EN
      chk("stream_cnt", 32'(enc_cnt_o), 32'd8);
`endif

      // Reset with both stages full must flush everything
      rsp_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive_rand();
         req_valid_i = 1'b1;
         step();
      end
      req_valid_i = 1'b0;
      rst_i       = 1'b1;
      step();
      chk("flush_rsp_valid", 32'(rsp_valid_o), 32'd0);
      rst_i = 1'b0;
      exp_q.delete();
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("flush_no_stale", 32'(rsp_valid_o), 32'd0);
      end

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         drive_rand();
         req_valid_i = 1'($urandom_range(0, 1));
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         step();
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
